// File: rtl/sqrt_arb_pkg.sv
// Shared types and sizing helpers for the sqrt arbiter/scheduler.
// Defaults here match the sqrt core build used by the FPU.
package sqrt_arb_pkg;

  function automatic int clog2_f(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  localparam int P_NREQ       = 4;
  localparam int P_WIDTH      = 26;
  localparam int P_STAGES     = 6;
  localparam int P_OBUF_DEPTH = 4;

  localparam int ID_W = clog2_f(P_NREQ);
  localparam int LAT  = P_STAGES - 1;

  typedef struct packed {
    logic [P_WIDTH-1:0] data;
    logic               sticky;
    logic [ID_W-1:0]    id;
  } rsp_entry_t;

endpackage

// File: rtl/sqrt_arb_sched_if.sv
// Requester, core and response signals of the sqrt scheduler.
// slave = scheduler side, master = FPU/core/consumer side.
interface sqrt_arb_sched_if
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ  = P_NREQ,
  parameter int WIDTH = P_WIDTH
);
  localparam int IW = clog2_f(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [WIDTH-1:0]      core_in;
  logic [WIDTH-1:0]      core_out;
  logic                  core_sticky;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_sticky;
  logic [IW-1:0]         rsp_id;

  modport slave (
    input  req_valid, req_data,
    input  core_out, core_sticky,
    input  rsp_ready,
    output req_ready, core_in,
    output rsp_valid, rsp_data,
    output rsp_sticky, rsp_id
  );

  modport master (
    output req_valid, req_data,
    output core_out, core_sticky,
    output rsp_ready,
    input  req_ready, core_in,
    input  rsp_valid, rsp_data,
    input  rsp_sticky, rsp_id
  );

endinterface

// File: rtl/sqrt_arb_rr.sv
// Combinational round-robin picker: first set req at or after ptr.
// any reflects raw requests; gnt_onehot is gated by en.
module sqrt_arb_rr
  import sqrt_arb_pkg::*;
#(
  parameter int N  = P_NREQ,
  parameter int IW = clog2_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int ki;
    logic [IW-1:0] k;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = 0; i < N; i++) begin
      ki = (int'(ptr) + i) % N;
      k  = ki[IW-1:0];
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt_idx = k;
      end
    end
    gnt_onehot[gnt_idx] = en & any;
  end

endmodule

// File: rtl/sqrt_arb_sched.sv
// Shares one non-stalling sqrt core among NREQ requesters, credit-guarded
// result FIFO. Define SQRT_ARB_PERF_EN to add saturating perf counters.
module sqrt_arb_sched
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ       = P_NREQ,
  parameter int WIDTH      = P_WIDTH,
  parameter int STAGES     = P_STAGES,
  parameter int OBUF_DEPTH = P_OBUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  sqrt_arb_sched_if.slave bus
`ifdef SQRT_ARB_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_credit_stall,
  output logic [31:0] perf_rsp_stall
`endif
);

  localparam int IW = clog2_f(NREQ);
  localparam int L  = STAGES - 1;
  localparam int PW = clog2_f(OBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sticky;
    logic [IW-1:0]    id;
  } ent_t;

  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] credits;
  logic [L-1:0]  sf_v;
  logic [IW-1:0] sf_id [L];

  ent_t          mem [OBUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   g;
  logic [IW-1:0]   g_nxt;
  logic            any_v;
  logic            can_issue;
  logic            issue;
  logic            empty;
  logic            tail_v;
  logic            pop;
  logic            pop_mem;
  logic            push;
  ent_t            tail;
  ent_t            head;

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] x
  );
    int t;
    t = (int'(x) + 1) % NREQ;
    return t[IW-1:0];
  endfunction

  // An empty FIFO passes the arriving result straight through,
  // so a result is visible in the cycle it leaves the core.
  assign empty   = (count == '0);
  assign tail_v  = sf_v[L-1];
  assign tail    = {bus.core_out, bus.core_sticky, sf_id[L-1]};
  assign head    = empty ? tail : mem[rd_ptr];
  assign pop     = bus.rsp_valid && bus.rsp_ready;
  assign pop_mem = pop && !empty;
  assign push    = tail_v && !(empty && pop);

  assign bus.rsp_valid  = !empty || tail_v;
  assign bus.rsp_data   = bus.rsp_valid ? head.data : '0;
  assign bus.rsp_sticky = bus.rsp_valid && head.sticky;
  assign bus.rsp_id     = bus.rsp_valid ? head.id : '0;

  // A pop this cycle frees a slot, so issue may use it at once.
  assign can_issue = rst && ((credits != '0) || pop);
  assign issue     = can_issue && any_v;
  assign g_nxt     = wrap_inc(g);

  sqrt_arb_rr #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req        (bus.req_valid),
    .ptr        (rr_ptr),
    .en         (can_issue),
    .gnt_onehot (gnt),
    .gnt_idx    (g),
    .any        (any_v)
  );

  assign bus.req_ready = gnt;
  assign bus.core_in   = issue
    ? bus.req_data[int'(g)*WIDTH +: WIDTH]
    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      credits <= CW'(OBUF_DEPTH);
    end else begin
      if (issue) rr_ptr <= g_nxt;
      credits <= credits - CW'(issue) + CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sf_v <= '0;
      for (int i = 0; i < L; i++) sf_id[i] <= '0;
    end else begin
      sf_v[0]  <= issue;
      sf_id[0] <= g;
      for (int i = 1; i < L; i++) begin
        sf_v[i]  <= sf_v[i-1];
        sf_id[i] <= sf_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (pop_mem) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tail;
  end

`ifdef SQRT_ARB_PERF_EN
  logic cs_ev;
  logic rs_ev;

  assign cs_ev = (|bus.req_valid) && (credits == '0);
  assign rs_ev = bus.rsp_valid && !bus.rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued       <= '0;
      perf_credit_stall <= '0;
      perf_rsp_stall    <= '0;
    end else begin
      if (issue && perf_issued != '1)
        perf_issued <= perf_issued + 32'd1;
      if (cs_ev && perf_credit_stall != '1)
        perf_credit_stall <= perf_credit_stall + 32'd1;
      if (rs_ev && perf_rsp_stall != '1)
        perf_rsp_stall <= perf_rsp_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sqrt_arb_sched.sv
// Bench for sqrt_arb_sched: behavioural sqrt core plus a scoreboard
// predicting grants, response timing and contents every cycle.
module tb_sqrt_arb_sched;
  import sqrt_arb_pkg::*;

  localparam int NREQ       = P_NREQ;
  localparam int WIDTH      = P_WIDTH;
  localparam int OBUF_DEPTH = P_OBUF_DEPTH;

  typedef struct {
    rsp_entry_t e;
    int         due;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_arb_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef SQRT_ARB_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_credit_stall;
  logic [31:0] perf_rsp_stall;
`endif

  sqrt_arb_sched #(
    .NREQ       (NREQ),
    .WIDTH      (WIDTH),
    .STAGES     (P_STAGES),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SQRT_ARB_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_credit_stall (perf_credit_stall),
    .perf_rsp_stall    (perf_rsp_stall)
`endif
  );

  function automatic logic [WIDTH:0] core_f(
    input logic [WIDTH-1:0] x
  );
    longint unsigned v, r, t;
    v = 64'(x) << WIDTH;
    r = 0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return {r[WIDTH-1:0], (r * r != v)};
  endfunction

  logic [WIDTH:0] cpipe [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) cpipe[i] <= '0;
    end else begin
      cpipe[0] <= core_f(bus.core_in);
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign bus.core_out    = cpipe[LAT-1][WIDTH:1];
  assign bus.core_sticky = cpipe[LAT-1][0];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  sb_t sb [$];
  int  gnt_log [$];
  int  rid_log [$];
  int  m_cred = OBUF_DEPTH;
  int  m_ptr = 0;
  int  obs_out = 0;
  int  m_issued = 0;
  int  m_cstall = 0;
  int  m_rstall = 0;

  int               s_cycle;
  logic [NREQ-1:0]  s_rdy;
  logic             s_rv;
  logic [WIDTH-1:0] s_rdata;
  logic             s_rst;
  logic [ID_W-1:0]  s_rid;

  task automatic model_clear();
    sb.delete();
    m_cred   = OBUF_DEPTH;
    m_ptr    = 0;
    obs_out  = 0;
    m_issued = 0;
    m_cstall = 0;
    m_rstall = 0;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NREQ; k++)
      bus.req_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // One clock cycle: sample at negedge+1, predict, compare, advance.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    logic [ID_W-1:0] ki;
    logic [WIDTH:0]  res;
    logic            exp_rv, exp_pop, exp_can;
    int              g, k;
    sb_t             it;
    #1;
    s_cycle = cyc;
    s_rdy   = bus.req_ready;
    s_rv    = bus.rsp_valid;
    s_rdata = bus.rsp_data;
    s_rst   = bus.rsp_sticky;
    s_rid   = bus.rsp_id;
    exp_rv  = (sb.size() > 0) && (sb[0].due <= cyc);
    n_total++;
    if (s_rv !== exp_rv)
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b",
               cyc, s_rv, exp_rv);
    else n_pass++;
    if (exp_rv && s_rv) begin
      n_total++;
      if (rsp_entry_t'({s_rdata, s_rst, s_rid}) !== sb[0].e)
        $display("FAIL rsp_entry cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                 cyc, s_rdata, s_rst, s_rid, sb[0].e.data,
                 sb[0].e.sticky, sb[0].e.id);
      else n_pass++;
    end
    exp_pop = exp_rv && bus.rsp_ready;
    exp_can = (m_cred != 0) || exp_pop;
    g = -1;
    if (exp_can) begin
      for (int i = 0; i < NREQ; i++) begin
        k  = (m_ptr + i) % NREQ;
        ki = k[ID_W-1:0];
        if (g < 0 && bus.req_valid[ki]) g = k;
      end
    end
    exp_rdy = '0;
    ki = g[ID_W-1:0];
    if (g >= 0) exp_rdy[ki] = 1'b1;
    n_total++;
    if (s_rdy !== exp_rdy)
      $display("FAIL req_ready cyc=%0d got=%b exp=%b",
               cyc, s_rdy, exp_rdy);
    else n_pass++;
    if (g >= 0) begin
      n_total++;
      if (bus.core_in !== bus.req_data[g*WIDTH +: WIDTH])
        $display("FAIL core_in cyc=%0d got=%h exp=%h", cyc,
                 bus.core_in, bus.req_data[g*WIDTH +: WIDTH]);
      else n_pass++;
      res         = core_f(bus.req_data[g*WIDTH +: WIDTH]);
      it.e.data   = res[WIDTH:1];
      it.e.sticky = res[0];
      it.e.id     = ki;
      it.due      = cyc + LAT;
      sb.push_back(it);
      gnt_log.push_back(g);
      m_ptr = (g + 1) % NREQ;
      m_issued++;
    end
    if ((|bus.req_valid) && m_cred == 0) m_cstall++;
    if (exp_rv && !bus.rsp_ready) m_rstall++;
    if (s_rv && bus.rsp_ready) rid_log.push_back(int'(s_rid));
    if (s_rdy != '0) obs_out++;
    if (s_rv && bus.rsp_ready) obs_out--;
    n_total++;
    assert (obs_out <= OBUF_DEPTH) n_pass++;
    else $display("FAIL fifo_overflow cyc=%0d got=%0d max=%0d",
                  cyc, obs_out, OBUF_DEPTH);
    if (exp_pop) void'(sb.pop_front());
    m_cred = m_cred - ((g >= 0) ? 1 : 0) + (exp_pop ? 1 : 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    rand_data();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (bus.req_ready !== '0)
      $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready);
    else n_pass++;
    n_total++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== '0)
      $display("FAIL rst_rsp_data got=%h exp=0", bus.rsp_data);
    else n_pass++;
    n_total++;
    if (bus.rsp_sticky !== 1'b0)
      $display("FAIL rst_rsp_sticky got=%b exp=0", bus.rsp_sticky);
    else n_pass++;
    n_total++;
    if (bus.rsp_id !== '0)
      $display("FAIL rst_rsp_id got=%0d exp=0", bus.rsp_id);
    else n_pass++;
    n_total++;
    if (bus.core_in !== '0)
      $display("FAIL rst_core_in got=%h exp=0", bus.core_in);
    else n_pass++;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
  endtask

  task automatic test_single_op();
    int n0, first;
    logic [WIDTH-1:0] d;
    logic st;
    logic [ID_W-1:0] id;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data[0 +: WIDTH] = 26'h1000000;
    tick();
    n0 = s_cycle;
    n_total++;
    if (s_rdy !== 4'b0001)
      $display("FAIL single_grant got=%b exp=0001", s_rdy);
    else n_pass++;
    bus.req_valid = '0;
    first = -1;
    d = '0; st = 1'b0; id = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_rv && first < 0) begin
        first = s_cycle; d = s_rdata; st = s_rst; id = s_rid;
      end
    end
    n_total++;
    if (first !== n0 + 5)
      $display("FAIL single_latency got=%0d exp=%0d",
               first - n0, 5);
    else n_pass++;
    n_total++;
    if (d !== 26'h2000000)
      $display("FAIL single_data got=%h exp=2000000", d);
    else n_pass++;
    n_total++;
    if (st !== 1'b0 || id !== '0)
      $display("FAIL single_sticky_id got=%b/%0d exp=0/0", st, id);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    gnt_log.delete();
    rid_log.delete();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      tick();
    end
    bus.req_valid = '0;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (gnt_log.size() < 12)
      $display("FAIL rr_count got=%0d exp>=12", gnt_log.size());
    else n_pass++;
    n = (gnt_log.size() < 12) ? gnt_log.size() : 12;
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (gnt_log[i] !== i % NREQ)
        $display("FAIL rr_grant[%0d] got=%0d exp=%0d",
                 i, gnt_log[i], i % NREQ);
      else n_pass++;
    end
    n = (rid_log.size() < 12) ? rid_log.size() : 12;
    n_total++;
    if (n !== 12)
      $display("FAIL rr_rsp_count got=%0d exp=12", n);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (rid_log[i] !== i % NREQ)
        $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d",
                 i, rid_log[i], i % NREQ);
      else n_pass++;
    end
  endtask

  task automatic run_flood(output int ngr);
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    rand_data();
    ngr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_rdy != '0) ngr++;
    end
  endtask

  task automatic test_credit_stall();
    int ngr;
    run_flood(ngr);
    n_total++;
    if (ngr !== OBUF_DEPTH)
      $display("FAIL flood_grants got=%0d exp=%0d", ngr, OBUF_DEPTH);
    else n_pass++;
    n_total++;
    if (s_rdy !== '0)
      $display("FAIL flood_stalled got=%b exp=0000", s_rdy);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    tick();
    n_total++;
    if (s_rv !== 1'b1 || s_rdy !== 4'b0001)
      $display("FAIL flood_resume got=%b/%b exp=1/0001", s_rv, s_rdy);
    else n_pass++;
    bus.req_valid = '0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_credit_one();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    rand_data();
    for (int i = 0; i < 3; i++) tick();
    bus.req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    rand_data();
    tick();
    n_total++;
    if (s_rv !== 1'b1 || s_rdy !== 4'b0001)
      $display("FAIL c1_pop_issue got=%b/%b exp=1/0001", s_rv, s_rdy);
    else n_pass++;
    bus.rsp_ready = 1'b0;
    rand_data();
    tick();
    n_total++;
    if (s_rdy !== 4'b0001)
      $display("FAIL c1_credit_kept got=%b exp=0001", s_rdy);
    else n_pass++;
    tick();
    n_total++;
    if (s_rdy !== 4'b0000)
      $display("FAIL c1_credit_used got=%b exp=0000", s_rdy);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    rand_data();
    for (int i = 0; i < 3; i++) tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    bus.req_valid = '1;
    #1;
    n_total++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 ||
        bus.core_in !== '0)
      $display("FAIL midrst_outputs got=%b/%b/%h exp=0000/0/0",
               bus.req_ready, bus.rsp_valid, bus.core_in);
    else n_pass++;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_rv) seen++;
    end
    n_total++;
    if (seen !== 0)
      $display("FAIL midrst_stale got=%0d exp=0", seen);
    else n_pass++;
  endtask

`ifdef SQRT_ARB_PERF_EN
  task automatic test_perf();
    int ngr;
    run_flood(ngr);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_total++;
    if (perf_issued !== 32'(m_issued))
      $display("FAIL perf_issued got=%0d exp=%0d",
               perf_issued, m_issued);
    else n_pass++;
    n_total++;
    if (perf_credit_stall !== 32'(m_cstall))
      $display("FAIL perf_credit_stall got=%0d exp=%0d",
               perf_credit_stall, m_cstall);
    else n_pass++;
    n_total++;
    if (perf_rsp_stall !== 32'(m_rstall))
      $display("FAIL perf_rsp_stall got=%0d exp=%0d",
               perf_rsp_stall, m_rstall);
    else n_pass++;
    bus.req_valid = '0;
    for (int i = 0; i < 10; i++) tick();
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_credit_stall();
    test_credit_one();
    test_reset_mid();
`ifdef SQRT_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
